// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, imem handshake, stall buffer and branch/jump redirects
// Optional FETCH_PERF_EN builds the fetch_count/stall_cycles counters; otherwise both read 0.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_INST = 32'h00000020
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [27:0] jump_target,
  input  logic [31:0] jump_pc4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc4_out,
  output logic        valid_out,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HELD  = 2'd1,
    S_KILL  = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_buf_inst, w_buf_inst_nxt;
  logic [31:0] r_buf_pc4, w_buf_pc4_nxt;
  logic [31:0] r_redir_pc, w_redir_pc_nxt;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc4;
  logic        w_req;
  logic        w_valid;
  logic [31:0] w_inst;
  logic [31:0] w_pc4_out;
  logic        w_unused_bits;

  // Branch wins over jump; target low bits are dropped to keep fetches word aligned.
  assign w_redirect    = branch_taken | jump;
  assign w_target      = branch_taken ? {branch_target[31:2], 2'b00}
                                      : {jump_pc4[31:28], jump_target[27:2], 2'b00};
  assign w_pc4         = r_pc + 32'd4;
  assign w_unused_bits = ^{branch_target[1:0], jump_target[1:0], jump_pc4[27:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_pc       <= {RESET_PC[31:2], 2'b00};
      r_buf_inst <= '0;
      r_buf_pc4  <= '0;
      r_redir_pc <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_buf_inst <= w_buf_inst_nxt;
      r_buf_pc4  <= w_buf_pc4_nxt;
      r_redir_pc <= w_redir_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_buf_inst_nxt = r_buf_inst;
    w_buf_pc4_nxt  = r_buf_pc4;
    w_redir_pc_nxt = r_redir_pc;
    w_req          = 1'b0;
    w_valid        = 1'b0;
    w_inst         = NOP_INST;
    w_pc4_out      = '0;
    unique case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (w_redirect) begin
          if (imem_ready) begin
            w_pc_nxt = w_target;
          end else begin
            w_redir_pc_nxt = w_target;
            w_state_nxt    = S_KILL;
          end
        end else if (imem_ready) begin
          w_pc_nxt = w_pc4;
          if (stall) begin
            w_buf_inst_nxt = imem_rdata;
            w_buf_pc4_nxt  = w_pc4;
            w_state_nxt    = S_HELD;
          end else begin
            w_inst    = imem_rdata;
            w_pc4_out = w_pc4;
            w_valid   = 1'b1;
          end
        end
      end
      S_HELD: begin
        if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_FETCH;
        end else if (!stall) begin
          w_inst      = r_buf_inst;
          w_pc4_out   = r_buf_pc4;
          w_valid     = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_KILL: begin
        // The outstanding request must complete at its original address before redirecting.
        w_req = 1'b1;
        if (w_redirect) begin
          w_redir_pc_nxt = w_target;
        end
        if (imem_ready) begin
          w_pc_nxt    = w_redirect ? w_target : r_redir_pc;
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  assign imem_req  = rst_n & w_req;
  assign imem_addr = r_pc;
  assign inst_out  = rst_n ? w_inst : NOP_INST;
  assign pc4_out   = rst_n ? w_pc4_out : 32'd0;
  assign valid_out = rst_n & w_valid;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count  <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (valid_out) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (stall) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  assign fetch_count  = r_fetch_count;
  assign stall_cycles = r_stall_cycles;
`else
  assign fetch_count  = '0;
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage: directed scenarios then random traffic
// Expected counter values follow FETCH_PERF_EN.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000020;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [27:0] jump_target;
  logic [31:0] jump_pc4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic [31:0] pc4_out;
  logic        valid_out;
  logic [31:0] fetch_count;
  logic [31:0] stall_cycles;

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .jump_pc4     (jump_pc4),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .inst_out     (inst_out),
    .pc4_out      (pc4_out),
    .valid_out    (valid_out),
    .fetch_count  (fetch_count),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } word_t;

  // Reference model: a PC, at most one parked instruction, at most one pending redirect.
  logic [31:0] m_pc;
  word_t       m_buf[$];
  logic [31:0] m_pend[$];
  logic [31:0] m_fetches;
  logic [31:0] m_stalls;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  function automatic logic [31:0] exp_cnt(input logic [31:0] c);
`ifdef FETCH_PERF_EN
    return c;
`else
    return 32'd0 & c;
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_buf.delete();
    m_pend.delete();
    m_fetches = 0;
    m_stalls  = 0;
  endtask

  task automatic check_in_reset(input string tag);
    check_eq({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    check_eq({tag, "_inst"},  inst_out, NOP);
    check_eq({tag, "_pc4"},   pc4_out, 32'd0);
    check_eq({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
    check_eq({tag, "_fcnt"},  fetch_count, 32'd0);
    check_eq({tag, "_scnt"},  stall_cycles, 32'd0);
  endtask

  // One clock cycle: drive inputs, predict outputs from the model, compare, advance the model.
  task automatic step(input logic s, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [27:0] jt, input logic [31:0] jpc4,
                      input logic rdy);
    logic        redir;
    logic [31:0] tgt;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
    word_t       w;
    @(negedge clk);
    stall         = s;
    branch_taken  = br;
    branch_target = bt;
    jump          = jp;
    jump_target   = jt;
    jump_pc4      = jpc4;
    imem_ready    = rdy;
    imem_rdata    = mem_word(m_pc);
    redir   = br | jp;
    tgt     = br ? {bt[31:2], 2'b00} : {jpc4[31:28], jt[27:2], 2'b00};
    e_req   = 1'b0;
    e_valid = 1'b0;
    e_addr  = m_pc;
    e_inst  = NOP;
    e_pc4   = 32'd0;
    #1;
    check_eq("fetch_count",  fetch_count,  exp_cnt(m_fetches));
    check_eq("stall_cycles", stall_cycles, exp_cnt(m_stalls));
    if (m_pend.size() != 0) begin
      e_req = 1'b1;
      if (redir) m_pend[0] = tgt;
      if (rdy) m_pc = m_pend.pop_front();
    end else if (m_buf.size() != 0) begin
      if (redir) begin
        m_buf.delete();
        m_pc = tgt;
      end else if (!s) begin
        w       = m_buf.pop_front();
        e_inst  = w.inst;
        e_pc4   = w.pc4;
        e_valid = 1'b1;
      end
    end else begin
      e_req = 1'b1;
      if (redir) begin
        if (rdy) m_pc = tgt;
        else m_pend.push_back(tgt);
      end else if (rdy) begin
        if (s) begin
          w.inst = mem_word(m_pc);
          w.pc4  = m_pc + 32'd4;
          m_buf.push_back(w);
        end else begin
          e_inst  = mem_word(m_pc);
          e_pc4   = m_pc + 32'd4;
          e_valid = 1'b1;
        end
        m_pc = m_pc + 32'd4;
      end
    end
    check_eq("imem_req", {31'd0, imem_req}, {31'd0, e_req});
    if (e_req) check_eq("imem_addr", imem_addr, e_addr);
    check_eq("inst_out",  inst_out, e_inst);
    check_eq("pc4_out",   pc4_out, e_pc4);
    check_eq("valid_out", {31'd0, valid_out}, {31'd0, e_valid});
    if (e_valid) m_fetches = m_fetches + 32'd1;
    if (s) m_stalls = m_stalls + 32'd1;
  endtask

  task automatic idle(input logic s, input logic rdy);
    step(s, 1'b0, 32'd0, 1'b0, 28'd0, 32'd0, rdy);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; jump_pc4 = '0; imem_ready = 1'b0; imem_rdata = '0;
    model_reset();
    #12;
    check_in_reset("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Zero-wait streaming from RESET_PC
    idle(1'b0, 1'b1);
    check_eq("tp1_addr0", imem_addr, 32'h0);
    check_eq("tp1_inst0", inst_out, 32'h100);
    check_eq("tp1_pc40", pc4_out, 32'h4);
    idle(1'b0, 1'b1);
    check_eq("tp1_inst1", inst_out, 32'h104);
    check_eq("tp1_pc41", pc4_out, 32'h8);
    idle(1'b0, 1'b1);
    check_eq("tp1_inst2", inst_out, 32'h108);
    check_eq("tp1_pc42", pc4_out, 32'hC);

    // Memory wait at pc=8
    step(1'b0, 1'b1, 32'h8, 1'b0, 28'd0, 32'd0, 1'b1);
    idle(1'b0, 1'b0);
    check_eq("tp2_hold_addr0", imem_addr, 32'h8);
    idle(1'b0, 1'b0);
    check_eq("tp2_hold_addr1", imem_addr, 32'h8);
    check_eq("tp2_hold_valid", {31'd0, valid_out}, 32'd0);
    idle(1'b0, 1'b1);
    check_eq("tp2_inst", inst_out, 32'h108);
    check_eq("tp2_pc4", pc4_out, 32'hC);

    // Three stall cycles on a hit at pc=4
    step(1'b0, 1'b1, 32'h4, 1'b0, 28'd0, 32'd0, 1'b1);
    idle(1'b1, 1'b1);
    check_eq("tp3_nop0", inst_out, NOP);
    idle(1'b1, 1'b1);
    check_eq("tp3_req_held", {31'd0, imem_req}, 32'd0);
    idle(1'b1, 1'b1);
    idle(1'b0, 1'b1);
    check_eq("tp3_release_inst", inst_out, 32'h104);
    check_eq("tp3_release_pc4", pc4_out, 32'h8);
    idle(1'b0, 1'b1);
    check_eq("tp3_next_addr", imem_addr, 32'h8);

    // Redirects while a request is outstanding: newest wins
    step(1'b0, 1'b1, 32'h10, 1'b0, 28'd0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 32'h40, 1'b0, 28'd0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 28'h80, 32'h0, 1'b0);
    check_eq("tp4_kill_addr", imem_addr, 32'h10);
    idle(1'b0, 1'b1);
    check_eq("tp4_kill_valid", {31'd0, valid_out}, 32'd0);
    idle(1'b0, 1'b1);
    check_eq("tp4_new_addr", imem_addr, 32'h80);

    // Simultaneous branch and jump; PC wrap at the top of memory
    step(1'b0, 1'b1, 32'h200, 1'b1, 28'h300, 32'h0, 1'b1);
    idle(1'b0, 1'b0);
    check_eq("tp5_branch_wins", imem_addr, 32'h200);
    step(1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 28'd0, 32'd0, 1'b1);
    idle(1'b0, 1'b1);
    check_eq("tp5_top_inst", inst_out, 32'h000000FC);
    check_eq("tp5_top_pc4", pc4_out, 32'h0);
    idle(1'b0, 1'b0);
    check_eq("tp5_wrap_addr", imem_addr, 32'h0);

    // Asynchronous reset while holding a stalled instruction
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_in_reset("tp6_reset");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1'b0, 1'b1);
    check_eq("tp6_restart_addr", imem_addr, 32'h0);
    check_eq("tp6_restart_inst", inst_out, 32'h100);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, $urandom(),
           $urandom_range(0, 9) == 0, 28'($urandom()), $urandom(),
           $urandom_range(0, 9) < 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

- Instruction-fetch stage: sits directly upstream of the IF/ID pipeline register and drives its `inst`/`pc4in` inputs every cycle.
- Owns the program counter and the instruction-memory request handshake.
- Holds a fetched instruction across downstream stalls.
- Applies branch/jump redirects, presenting the NOP bubble (32'h00000020) whenever no valid instruction is available.

## Interface
Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset
- NOP_INST, 32'h00000020, bubble instruction presented when valid_out=0

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hazard unit: downstream must not advance this cycle
- branch_taken  in  1  taken branch resolved in EX/MEM
- branch_target  in  32  branch destination (EX/MEM adder result)
- jump  in  1  jump resolved in ID/EX
- jump_target  in  28  shifted jump field
- jump_pc4  in  32  PC+4 of the jump; upper 4 bits form target
- imem_req  out  1  memory request
- imem_addr  out  32  request address, word aligned
- imem_ready  in  1  memory accepts request and returns data this cycle
- imem_rdata  in  32  instruction word, valid when imem_req & imem_ready
- inst_out  out  32  instruction to IF/ID
- pc4_out  out  32  PC+4 of inst_out; 0 when valid_out=0
- valid_out  out  1  inst_out is a real instruction
- fetch_count  out  32  retired fetches (see Configuration)
- stall_cycles  out  32  cycles with stall=1 (see Configuration)

## Operation
State registers:
- pc (32)
- state ∈ {FETCH, HELD, KILL}
- buf_inst/buf_pc4 (32 each)
- redir_pc (32)

Redirect selection:
- redirect = branch_taken | jump
- target = branch_taken ? branch_target : {jump_pc4[31:28], jump_target}
- branch wins when both are asserted.

FETCH:
- Outputs: imem_req=1, imem_addr=pc.
- hit = imem_ready.
- redirect & hit: discard rdata; pc<=target; stay FETCH; output NOP.
- redirect & !hit: redir_pc<=target; go KILL; output NOP.
- hit & stall: buf<=(rdata, pc+4); pc<=pc+4; go HELD; output NOP.
- hit & !stall: output rdata, pc+4, valid_out=1; pc<=pc+4.
- !hit: output NOP; hold pc. imem_addr must stay stable while req & !ready.

HELD:
- imem_req=0.
- redirect: drop buffer; pc<=target; go FETCH.
- stall: output NOP; stay.
- else: output buf, valid_out=1; go FETCH.

KILL:
- imem_req=1, imem_addr=pc (old address, kept stable).
- Any further redirect overwrites redir_pc; the newest redirect wins.
- On imem_ready: discard data; pc<=redir_pc; go FETCH.
- Output NOP throughout; stall is ignored.

General rules:
- PC arithmetic is modulo 2^32; 32'hFFFFFFFC + 4 wraps to 0.
- imem_addr[1:0] is always 0; target low bits are forced to 0.

## Timing
Reset (rst_n low, asynchronous):
- pc=RESET_PC, state=FETCH, buffers and redir_pc=0, counters=0.
- While rst_n is low: imem_req=0, inst_out=NOP_INST, pc4_out=0, valid_out=0.

Latency and throughput:
- First request is issued in the first cycle after rst_n deasserts.
- Zero-wait memory: the instruction appears on inst_out combinationally in the hit cycle and is captured by IF/ID at the next edge.
- Throughput: 1 instruction/cycle.
- Each memory wait cycle inserts one NOP.

Stall and redirect:
- Stall release from HELD: the buffered instruction is presented in the first cycle with stall=0, with no refetch.
- Redirect latency: target address is on imem_addr the cycle after redirect is sampled (FETCH/HELD). From KILL, it appears the cycle after imem_ready.
- Outputs are combinational from state, imem_rdata, and control inputs; no registered output stage.

## Configuration
FETCH_PERF_EN:
- Defined: fetch_count increments on every cycle valid_out=1; stall_cycles increments on every cycle stall=1 and rst_n=1. Both wrap at 2^32 and reset to 0.
- Undefined: both ports are tied to 0 and the counters are not built.

## Test plan
- Reset release, imem_ready=1 always, imem_rdata=addr+32'h100 -> consecutive cycles present inst 0x100,0x104,0x108 with pc4_out 4,8,12; valid_out=1 each cycle.
- imem_ready low for 2 cycles at pc=8 -> two NOP cycles with valid_out=0 and imem_addr held at 8; then inst for 8 with pc4_out=12.
- stall=1 for 3 cycles coincident with hit at pc=4 -> NOP×3, imem_req=0 in HELD; the release cycle presents the buffered word with pc4_out=8; next address is 8 with no refetch of 4.
- Redirect while waiting: at pc=0x10 not ready, branch_taken=1 target 0x40, then jump to 0x80 next cycle -> addr held 0x10 until ready, data dropped, next imem_addr=0x80, no valid output in between.
- branch_taken and jump in the same cycle (targets 0x200/0x300) -> pc=0x200; at pc=32'hFFFFFFFC a hit -> next pc 0.
- rst_n asserted mid-HELD -> outputs immediately NOP/valid 0/imem_req 0; after release, fetch restarts at RESET_PC. With FETCH_PERF_EN, both counters read 0.
